// File: rtl/modulo_n_down_counter.sv
// Modulo-N down counter: IDLE/COUNT/DONE FSM; load starts a countdown, tc pulses on the enabled edge at zero.
// Latency: all outputs are registered; load, step and tc take effect on the edge after their inputs are sampled.
// Flow control: enable low stalls the count without losing a step; optional wrap counter under `WRAP_CNT_EN`.
module modulo_n_down_counter #(
  parameter int N         = 13,
  parameter int cnt_width = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 load,
  input  logic [cnt_width-1:0] load_value,
  input  logic                 auto_reload,
  output logic [cnt_width-1:0] counter_out,
  output logic                 tc,
  output logic                 busy
`ifdef WRAP_CNT_EN
  ,
  output logic [7:0]           wrap_count
`endif
);

  // Largest legal count; N may equal 2**cnt_width, so N-1 always fits.
  localparam logic [cnt_width-1:0] MAX_VAL = cnt_width'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [cnt_width-1:0] cnt_nxt;
  logic                 tc_nxt;
  logic                 busy_nxt;
  logic [cnt_width-1:0] load_clamped;

`ifdef WRAP_CNT_EN
  logic [7:0] wrap_nxt;
`endif

  // Out-of-range load values are clamped so the count never leaves 0..N-1.
  always_comb begin
    load_clamped = (load_value > MAX_VAL) ? MAX_VAL : load_value;
  end

  // Next-state, next-count and registered-output values; load overrides any step.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = counter_out;
    tc_nxt    = 1'b0;
`ifdef WRAP_CNT_EN
    wrap_nxt  = wrap_count;
`endif
    if (load) begin
      state_nxt = COUNT;
      cnt_nxt   = load_clamped;
`ifdef WRAP_CNT_EN
      wrap_nxt  = 8'd0;
`endif
    end else begin
      case (state)
        COUNT: begin
          if (enable) begin
            if (counter_out != '0) begin
              cnt_nxt = counter_out - 1'b1;
            end else begin
              // Zero crossing: the only point where auto_reload is looked at.
              tc_nxt = 1'b1;
              if (auto_reload) begin
                cnt_nxt = MAX_VAL;
`ifdef WRAP_CNT_EN
                wrap_nxt = (wrap_count == 8'd255) ? wrap_count : wrap_count + 8'd1;
`endif
              end else begin
                state_nxt = DONE;
              end
            end
          end
        end
        IDLE:    state_nxt = IDLE;
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
    busy_nxt = (state_nxt == COUNT);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      counter_out <= MAX_VAL;
      tc          <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      counter_out <= cnt_nxt;
      tc          <= tc_nxt;
      busy        <= busy_nxt;
    end
  end

`ifdef WRAP_CNT_EN
  // Saturating count of auto-reload wraps, cleared by reset and by load.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wrap_count <= 8'd0;
    end else begin
      wrap_count <= wrap_nxt;
    end
  end
`endif

endmodule
